// File: rtl/cache_miss_sequencer.sv
// Blocking cache-miss sequencer: stalls the pipeline through writeback/refill/fill.
// Optional CACHE_STATS_EN macro adds saturating hit/miss/writeback counters.
module cache_miss_sequencer #(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic        cache_hit,
  input  logic        cache_dirty,
  output logic        pc_enable,
  output logic        we_cache,
  output logic        set_valid,
  output logic        set_dirty,
  output logic        cache_input_type,
  output logic        memory_address_type,
  output logic        we_memory,
  output logic        busy
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
  output logic [15:0] writeback_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FILL} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MEM_LATENCY - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req;
  logic       hit_ev;
  logic       miss_ev;
  logic       wb_ev;

  assign req = mem_read_req | mem_write_req;

  // Outputs are combinational: a write hit must be serviced in the same cycle.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    pc_enable           = 1'b0;
    we_cache            = 1'b0;
    set_valid           = 1'b0;
    set_dirty           = 1'b0;
    cache_input_type    = 1'b0;
    memory_address_type = 1'b0;
    we_memory           = 1'b0;
    busy                = 1'b0;
    hit_ev              = 1'b0;
    miss_ev             = 1'b0;
    wb_ev               = 1'b0;
    if (!reset) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          pc_enable = 1'b1;
          if (req && cache_hit) begin
            hit_ev = 1'b1;
            if (mem_write_req) begin
              we_cache         = 1'b1;
              cache_input_type = 1'b1;
              set_dirty        = 1'b1;
              set_valid        = 1'b1;
            end
          end else if (req) begin
            pc_enable = 1'b0;
            miss_ev   = 1'b1;
            wb_ev     = cache_dirty;
            cnt_d     = '0;
            state_d   = cache_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          we_memory           = 1'b1;
          memory_address_type = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = REFILL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        REFILL: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        FILL: begin
          we_cache  = 1'b1;
          set_valid = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic [15:0] wb_count_q, wb_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    if (hit_ev && hit_count_q != '1) hit_count_d = hit_count_q + 16'd1;
    if (miss_ev && miss_count_q != '1) miss_count_d = miss_count_q + 16'd1;
    if (wb_ev && wb_count_q != '1) wb_count_d = wb_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;
  assign writeback_count = wb_count_q;
`endif

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Scoreboard bench for cache_miss_sequencer: a transaction-level model queues
// the expected per-cycle output vector; a negedge monitor pops and compares.
module tb_cache_miss_sequencer;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_read_req = 1'b0, mem_write_req = 1'b0, cache_hit = 1'b0, cache_dirty = 1'b0;
  logic pc_enable, we_cache, set_valid, set_dirty, cache_input_type;
  logic memory_address_type, we_memory, busy;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count, writeback_count;
`endif

  always #5 clk = ~clk;

  cache_miss_sequencer #(.MEM_LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req),
    .cache_hit(cache_hit),
    .cache_dirty(cache_dirty),
    .pc_enable(pc_enable),
    .we_cache(we_cache),
    .set_valid(set_valid),
    .set_dirty(set_dirty),
    .cache_input_type(cache_input_type),
    .memory_address_type(memory_address_type),
    .we_memory(we_memory),
    .busy(busy)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count),
    .writeback_count(writeback_count)
`endif
  );

  // Vector layout: {pc_enable, we_cache, set_valid, set_dirty,
  //                 cache_input_type, memory_address_type, we_memory, busy}
  localparam logic [7:0] V_RESET = 8'b0000_0000;
  localparam logic [7:0] V_IDLE  = 8'b1000_0000;
  localparam logic [7:0] V_WHIT  = 8'b1111_1000;
  localparam logic [7:0] V_MISS  = 8'b0000_0000;
  localparam logic [7:0] V_WB    = 8'b0000_0111;
  localparam logic [7:0] V_REF   = 8'b0000_0001;
  localparam logic [7:0] V_FILL  = 8'b0110_0001;

  logic [7:0] sb[$];
  logic [7:0] pend[$];
  int unsigned m_hits = 0, m_miss = 0, m_wb = 0;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: a miss expands into the full list of stall-cycle vectors it will cause.
  function automatic logic [7:0] model(input logic r, rd, wr, hit, dirty);
    logic [7:0] e;
    if (r) begin
      pend.delete();
      m_hits = 0; m_miss = 0; m_wb = 0;
      return V_RESET;
    end
    if (pend.size() > 0) return pend.pop_front();
    if (!(rd || wr)) return V_IDLE;
    if (hit) begin
      if (m_hits < 16'hFFFF) m_hits++;
      return wr ? V_WHIT : V_IDLE;
    end
    if (m_miss < 16'hFFFF) m_miss++;
    if (dirty) begin
      if (m_wb < 16'hFFFF) m_wb++;
      for (int unsigned i = 0; i < LAT; i++) pend.push_back(V_WB);
    end
    for (int unsigned i = 0; i < LAT; i++) pend.push_back(V_REF);
    pend.push_back(V_FILL);
    e = V_MISS;
    return e;
  endfunction

  task automatic drive(input logic r, rd, wr, hit, dirty);
    @(posedge clk);
    #1;
    reset = r; mem_read_req = rd; mem_write_req = wr;
    cache_hit = hit; cache_dirty = dirty;
    sb.push_back(model(r, rd, wr, hit, dirty));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    logic [7:0] act, exp_v;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        act = {pc_enable, we_cache, set_valid, set_dirty, cache_input_type,
               memory_address_type, we_memory, busy};
        n_checks++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, act, exp_v);
        end
      end
    end
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
    end
  endtask

  initial begin
    // Reset two cycles, then idle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(3);

    // Clean load miss, then the access hits.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(LAT) + 1; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(2);

    // Dirty store miss; after fill the store takes the write-hit path.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2 * int'(LAT) + 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(2);

    // Reset during second writeback cycle aborts the transfer.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_cycles(LAT * 3);

    // Both requests with a hit: store dominates.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_cycles(1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(63) == 0), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));

`ifdef CACHE_STATS_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) drive(1'b0, 1'b1, 1'($urandom), 1'b1, 1'($urandom));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2 * int'(LAT) + 1; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle_cycles(1);
    @(negedge clk);
    check16("hit_count_sat", hit_count, 16'hFFFF);
    check16("miss_count", miss_count, 16'(m_miss));
    check16("writeback_count", writeback_count, 16'(m_wb));
    check16("miss_count_three", miss_count, 16'd3);
    check16("writeback_count_three", writeback_count, 16'd3);
`endif

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_sequencer.md
CACHE_MISS_SEQUENCER -- requirements
Module: cache_miss_sequencer

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, main-memory access cycles per transfer (legal 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_read_req  input  1  current instruction is a load (LW/LB).
REQ-005 SHALL have port mem_write_req  input  1  current instruction is a store (SW/SB).
REQ-006 SHALL have port cache_hit  input  1  tag match and valid for the current address.
REQ-007 SHALL have port cache_dirty  input  1  victim line dirty.
REQ-008 SHALL have port pc_enable  output  1  PC/pipeline advance permitted.
REQ-009 SHALL have port we_cache  output  1  cache line write strobe.
REQ-010 SHALL have port set_valid  output  1  mark written line valid.
REQ-011 SHALL have port set_dirty  output  1  mark written line dirty.
REQ-012 SHALL have port cache_input_type  output  1  cache data source: 0 memory, 1 register file.
REQ-013 SHALL have port memory_address_type  output  1  memory address source: 0 ALU, 1 victim tag.
REQ-014 SHALL have port we_memory  output  1  main-memory write strobe.
REQ-015 SHALL have port busy  output  1  miss handling in progress (state not IDLE).

Function
REQ-016 SHALL implement states IDLE, WRITEBACK, REFILL, FILL; 8-bit cycle counter cnt.
REQ-017 SHALL treat mem_write_req as dominant when both requests are high in the same cycle.
REQ-018 In IDLE with no request: pc_enable=1, all other outputs 0, state held.
REQ-019 In IDLE, read hit: pc_enable=1, no cache/memory write, zero stall cycles.
REQ-020 In IDLE, write hit: pc_enable=1, we_cache=1, cache_input_type=1, set_dirty=1, set_valid=1, same cycle.
REQ-021 In IDLE, miss (request and !cache_hit): pc_enable=0, no writes; next state WRITEBACK if cache_dirty else REFILL; cnt cleared.
REQ-022 WRITEBACK: pc_enable=0, we_memory=1, memory_address_type=1; cnt increments; after MEM_LATENCY cycles (cnt==MEM_LATENCY-1) -> REFILL, cnt cleared.
REQ-023 REFILL: pc_enable=0, we_memory=0, memory_address_type=0; after MEM_LATENCY cycles -> FILL, cnt cleared.
REQ-024 FILL: one cycle, pc_enable=0, we_cache=1, cache_input_type=0, set_valid=1, set_dirty=0 -> IDLE.
REQ-025 After FILL, IDLE re-evaluates the access; a store then takes the write-hit path (REQ-020).
REQ-026 Miss latency: clean miss 1+MEM_LATENCY+1 stall cycles; dirty miss 1+2*MEM_LATENCY+1.
REQ-027 Request inputs SHALL be ignored outside IDLE.
REQ-028 Outputs SHALL be decoded from state (and, in IDLE only, from request/hit inputs); no latched outputs.

Reset
REQ-029 reset high at a clock edge SHALL force IDLE, cnt=0, from any state including mid-WRITEBACK/REFILL.
REQ-030 While reset is high: pc_enable=0, all other outputs 0; the aborted transfer SHALL not be resumed.

Configuration
REQ-031 Macro CACHE_STATS_EN, when defined, SHALL add outputs hit_count, miss_count, writeback_count (each 16 bits), cleared by reset.
REQ-032 With CACHE_STATS_EN: hit_count +1 per IDLE hit cycle; miss_count +1 per IDLE->WRITEBACK/REFILL transition; writeback_count +1 per IDLE->WRITEBACK; all saturate at 0xFFFF.
REQ-033 Without CACHE_STATS_EN: ports and counters absent; REQ-001..030 behaviour identical.

Verification
REQ-034 reset 2 cycles, then idle -> pc_enable=1, busy=0, all write strobes 0.
REQ-035 MEM_LATENCY=4, load, cache_hit=0, cache_dirty=0 -> pc_enable low 6 cycles: 4 REFILL, FILL with we_cache=1/set_valid=1/cache_input_type=0.
REQ-036 MEM_LATENCY=4, store, miss, cache_dirty=1 -> we_memory=1 and memory_address_type=1 for exactly 4 cycles, 4 REFILL, FILL, then write-hit cycle with set_dirty=1, cache_input_type=1.
REQ-037 reset asserted on 2nd WRITEBACK cycle -> next cycle IDLE, we_memory=0, busy=0; no FILL occurs.
REQ-038 both requests high with hit -> write-hit response (we_cache=1, set_dirty=1).
REQ-039 CACHE_STATS_EN, 70000 hit cycles -> hit_count=0xFFFF; 3 dirty misses -> miss_count=3, writeback_count=3.
